// File: rtl/xor_parity_pipe.sv
// ============================================================================
// Module   : xor_parity_pipe
// Purpose  : Pipelined 4-ary XOR-tree parity with odd/even mode and a
//            LAST-terminated multi-word running parity accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_parity_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             CK,
  input  logic             CD,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  input  logic             ODD,
  input  logic             LAST,
  output logic             Z,
  output logic             ZV,
  output logic             ACC,
  output logic             ACCV
);

  function automatic int calc_stages(input int w);
    int n;
    int s;
    n = (w + 3) / 4;
    s = 1;
    while (n > 1) begin
      n = (n + 3) / 4;
      s = s + 1;
    end
    return s;
  endfunction

  function automatic int lvl_width(input int k);
    int n;
    n = WIDTH;
    for (int i = 0; i < k; i++) n = (n + 3) / 4;
    return n;
  endfunction

  localparam int STAGES = calc_stages(WIDTH);

  logic raw;

  // Each level folds groups of four bits (top group zero-padded) into one flop.
  for (genvar k = 1; k <= STAGES; k++) begin : g_level
    localparam int IN_W  = lvl_width(k - 1);
    localparam int OUT_W = lvl_width(k);

    logic [IN_W-1:0]    src;
    logic [4*OUT_W-1:0] padded;
    logic [OUT_W-1:0]   xor_d;
    logic [OUT_W-1:0]   xor_q;

    if (k == 1) begin : g_from_input
      assign src = D;
    end else begin : g_from_level
      assign src = g_level[k-1].xor_q;
    end

    always_comb begin
      padded = '0;
      padded[IN_W-1:0] = src;
      for (int j = 0; j < OUT_W; j++) xor_d[j] = ^padded[4*j +: 4];
    end

    always_ff @(posedge CK) begin
      if (CD) xor_q <= '0;
      else    xor_q <= xor_d;
    end

    if (k == STAGES) begin : g_root
      assign raw = xor_q[0];
    end
  end

  logic [STAGES-1:0] dv_d, dv_q;
  logic [STAGES-1:0] odd_d, odd_q;
  logic [STAGES-1:0] last_d, last_q;

  always_comb begin
    dv_d      = '0;
    odd_d     = '0;
    last_d    = '0;
    dv_d[0]   = DV;
    odd_d[0]  = ODD;
    last_d[0] = LAST;
    for (int i = 1; i < STAGES; i++) begin
      dv_d[i]   = dv_q[i-1];
      odd_d[i]  = odd_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  // Output stage: Z carries the mode-adjusted parity, r keeps the raw bit for A.
  logic z_d, z_q, zv_d, zv_q, r_d, r_q, lo_d, lo_q;
  logic a_d, a_q, acc_d, acc_q, accv_d, accv_q;

  always_comb begin
    z_d    = raw ^ odd_q[STAGES-1];
    zv_d   = dv_q[STAGES-1];
    r_d    = raw;
    lo_d   = last_q[STAGES-1];
    a_d    = a_q;
    acc_d  = acc_q;
    accv_d = 1'b0;
    if (zv_q) begin
      if (lo_q) begin
        acc_d  = a_q ^ z_q;
        accv_d = 1'b1;
        a_d    = 1'b0;
      end else begin
        a_d    = a_q ^ r_q;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      dv_q   <= '0;
      odd_q  <= '0;
      last_q <= '0;
      z_q    <= 1'b0;
      zv_q   <= 1'b0;
      r_q    <= 1'b0;
      lo_q   <= 1'b0;
      a_q    <= 1'b0;
      acc_q  <= 1'b0;
      accv_q <= 1'b0;
    end else begin
      dv_q   <= dv_d;
      odd_q  <= odd_d;
      last_q <= last_d;
      z_q    <= z_d;
      zv_q   <= zv_d;
      r_q    <= r_d;
      lo_q   <= lo_d;
      a_q    <= a_d;
      acc_q  <= acc_d;
      accv_q <= accv_d;
    end
  end

  assign Z    = z_q;
  assign ZV   = zv_q;
  assign ACC  = acc_q;
  assign ACCV = accv_q;

endmodule

`default_nettype wire

// File: tb/tb_xor_parity_pipe.sv
// ============================================================================
// Module   : tb_xor_parity_pipe
// Purpose  : Scoreboard bench for xor_parity_pipe (WIDTH 16, 5 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_parity_pipe;

  typedef struct {
    logic val;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] d16 = '0;
  logic dv16 = 1'b0, odd16 = 1'b0, last16 = 1'b0;
  logic z16, zv16, acc16, accv16;

  logic [4:0] d5 = '0;
  logic dv5 = 1'b0, odd5 = 1'b0;
  logic z5, zv5, acc5, accv5;

  logic [0:0] d1 = '0;
  logic dv1 = 1'b0, odd1 = 1'b0;
  logic z1, zv1, acc1, accv1;

  exp_t qz[$];
  exp_t qa[$];
  exp_t q5[$];
  exp_t q1[$];

  xor_parity_pipe #(.WIDTH(16)) u_dut16 (
    .CK(clk), .CD(rst), .D(d16), .DV(dv16), .ODD(odd16), .LAST(last16),
    .Z(z16), .ZV(zv16), .ACC(acc16), .ACCV(accv16));

  xor_parity_pipe #(.WIDTH(5)) u_dut5 (
    .CK(clk), .CD(rst), .D(d5), .DV(dv5), .ODD(odd5), .LAST(1'b0),
    .Z(z5), .ZV(zv5), .ACC(acc5), .ACCV(accv5));

  xor_parity_pipe #(.WIDTH(1)) u_dut1 (
    .CK(clk), .CD(rst), .D(d1), .DV(dv1), .ODD(odd1), .LAST(1'b0),
    .Z(z1), .ZV(zv1), .ACC(acc1), .ACCV(accv1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: each pops its queue whenever the DUT presents a valid output.
  always @(negedge clk) begin
    exp_t e;
    if (zv16) begin
      checks++;
      if (qz.size() == 0) begin
        errors++;
        $display("FAIL z16_unexpected: got ZV=1 at cycle %0d, required no output", cyc);
      end else begin
        e = qz.pop_front();
        if (z16 !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL z16: got Z=%0b at cycle %0d, required Z=%0b at cycle %0d", z16, cyc, e.val, e.cyc);
        end
      end
    end else if (qz.size() != 0 && qz[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = qz.pop_front();
      $display("FAIL z16_missing: got ZV=0 at cycle %0d, required Z=%0b", cyc, e.val);
    end
    if (accv16) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL acc16_unexpected: got ACCV=1 at cycle %0d, required no output", cyc);
      end else begin
        e = qa.pop_front();
        if (acc16 !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL acc16: got ACC=%0b at cycle %0d, required ACC=%0b at cycle %0d", acc16, cyc, e.val, e.cyc);
        end
      end
    end else if (qa.size() != 0 && qa[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = qa.pop_front();
      $display("FAIL acc16_missing: got ACCV=0 at cycle %0d, required ACC=%0b", cyc, e.val);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (zv5) begin
      checks++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL z5_unexpected: got ZV=1 at cycle %0d, required no output", cyc);
      end else begin
        e = q5.pop_front();
        if (z5 !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL z5: got Z=%0b at cycle %0d, required Z=%0b at cycle %0d", z5, cyc, e.val, e.cyc);
        end
      end
    end else if (q5.size() != 0 && q5[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = q5.pop_front();
      $display("FAIL z5_missing: got ZV=0 at cycle %0d, required Z=%0b", cyc, e.val);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (zv1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL z1_unexpected: got ZV=1 at cycle %0d, required no output", cyc);
      end else begin
        e = q1.pop_front();
        if (z1 !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL z1: got Z=%0b at cycle %0d, required Z=%0b at cycle %0d", z1, cyc, e.val, e.cyc);
        end
      end
    end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = q1.pop_front();
      $display("FAIL z1_missing: got ZV=0 at cycle %0d, required Z=%0b", cyc, e.val);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Word driven now is sampled at edge cyc+1; Z follows 2 edges later, ACC 3.
  task automatic send(input logic [15:0] d, input logic odd, input logic last,
                      input logic push, input logic ez, input logic ea);
    @(negedge clk);
    d16 = d; dv16 = 1'b1; odd16 = odd; last16 = last;
    if (push) begin
      qz.push_back('{ez, cyc + 3});
      if (last) qa.push_back('{ea, cyc + 4});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dv16 = 1'b0; last16 = 1'b0; odd16 = 1'b0;
      dv5 = 1'b0; dv1 = 1'b0;
    end
  endtask

  task automatic send5(input logic [4:0] d, input logic odd, input logic ez);
    @(negedge clk);
    d5 = d; dv5 = 1'b1; odd5 = odd;
    q5.push_back('{ez, cyc + 3});
  endtask

  task automatic send1(input logic d, input logic odd, input logic ez);
    @(negedge clk);
    d1[0] = d; dv1 = 1'b1; odd1 = odd;
    q1.push_back('{ez, cyc + 2});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_z", int'(z16), 0);
    chk("rst_zv", int'(zv16), 0);
    chk("rst_acc", int'(acc16), 0);
    chk("rst_accv", int'(accv16), 0);

    // Single words, then a back-to-back burst closed by LAST (raw xor 1,0,0,0,1,0,1 = 1).
    send(16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    send(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    send(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    send(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'h8001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(4);

    // Three-word groups, even then odd on the LAST word.
    send(16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(16'h0007, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send(16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(16'h0007, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Groups with bubbles, then single-word groups on consecutive cycles.
    send(16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    send(16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    send(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    send(16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send(16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(4);

    // Open a group (A=1), put two words in flight, then reset for one cycle.
    send(16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    send(16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; d16 = 16'hFFFF; dv16 = 1'b1; last16 = 1'b1;
    @(negedge clk);
    rst = 1'b0; dv16 = 1'b0; last16 = 1'b0;
    chk("mid_rst_z", int'(z16), 0);
    chk("mid_rst_zv", int'(zv16), 0);
    chk("mid_rst_acc", int'(acc16), 0);
    chk("mid_rst_accv", int'(accv16), 0);
    idle(2);
    send(16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    send(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(5);

    // Narrow widths: zero-padded top group and the single-bit case.
    send5(5'h10, 1'b0, 1'b1);
    send5(5'h1F, 1'b0, 1'b1);
    send5(5'h11, 1'b0, 1'b0);
    idle(1);
    send1(1'b1, 1'b0, 1'b1);
    send1(1'b0, 1'b1, 1'b1);
    send1(1'b0, 1'b0, 1'b0);
    idle(6);

    chk("drain_z16", qz.size(), 0);
    chk("drain_acc16", qa.size(), 0);
    chk("drain_z5", q5.size(), 0);
    chk("drain_z1", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
